mem_sequencer: RTL and testbench
================================

# mem_sequencer

Memory access sequencer between the SLC-3 control unit/datapath and the external asynchronous SRAM plus memory-mapped I/O. It converts the control unit's level read/write requests into correctly timed SRAM strobes with a parameterised wait-state count. It returns a one-cycle completion pulse, and it decodes the I/O address to the switch input and hex-display register. Read data it returns is loaded into MDR by the datapath.

## Interface
- WAIT_CYC, 2: SRAM strobe-active cycles before read capture or write release; legal range ≥1.
- IO_ADDR, 16'hFFFF: address decoded as memory-mapped I/O instead of SRAM.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req_Rd  in  1  level read request (control unit Mem_OE).
- Req_Wr  in  1  level write request (control unit Mem_WE).
- Addr  in  16  access address (MAR).
- Wdata  in  16  write data (MDR).
- Rdata  out  16  registered read data to the MDR input mux.
- Done  out  1  one-cycle pulse: access complete, Rdata valid on a read.
- SRAM_ADDR  out  20  {4'b0, latched Addr}.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.
- SRAM_Din  in  16  SRAM data bus, read side.
- SRAM_Dout  out  16  SRAM data bus, write side.
- SRAM_Doe  out  1  bus drive enable; the top level owns the tristate.
- Switches  in  16  board switches, returned on an I/O read.
- Hex_out  out  16  hex-display register, loaded on an I/O write.

## Operation
- States: IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RELEASE.
- IDLE: Addr and Wdata are latched when a request is sampled.
  - Req_Rd wins if both requests are high.
  - An I/O address goes straight to DONE. On a read, Rdata <= Switches in that edge; on a write, Hex_out <= Wdata. No SRAM strobe is asserted for an I/O access.
  - An SRAM read goes to RD_WAIT; an SRAM write goes to WR_SETUP.
- RD_WAIT: CE_N=0, OE_N=0 for WAIT_CYC cycles, then RD_CAP.
- RD_CAP: strobes are still asserted; Rdata <= SRAM_Din; go to DONE.
- WR_SETUP: CE_N=0, WE_N=1, SRAM_Doe=1, SRAM_Dout=latched Wdata, held for 1 cycle.
- WR_PULSE: WE_N=0 for WAIT_CYC cycles, then WR_HOLD.
- WR_HOLD: WE_N=1 with data still driven, held for 1 cycle; then DONE.
- DONE: Done=1 for exactly one cycle, all strobes inactive, then RELEASE.
- RELEASE: hold until Req_Rd=0 and Req_Wr=0, then IDLE. A request held high across Done never starts a second access.
- UB_N and LB_N equal CE_N (word access only).
- Rdata holds its last value until the next read completes. Hex_out changes only on an I/O write.
- The wait counter loads WAIT_CYC-1 on entry to RD_WAIT or WR_PULSE and decrements to 0. Its width is $clog2(WAIT_CYC+1).

## Timing
- Reset values: state IDLE; all *_N = 1; SRAM_Doe 0; Done 0; Rdata 0; Hex_out 0; SRAM_ADDR 0; SRAM_Dout 0.
- Reset asserted mid-access deasserts every strobe and SRAM_Doe immediately, without waiting for a clock edge. No Done is issued for the aborted access.
- Strobes and SRAM_Doe are registered outputs: glitch-free and decoded from the next state.
- Latency is counted from the edge that samples the request in IDLE to the edge that raises Done:
  - SRAM read: WAIT_CYC+2 cycles.
  - SRAM write: WAIT_CYC+3 cycles.
  - I/O access: 1 cycle.
- SRAM_ADDR is stable from the sampling edge until DONE is left.
- SRAM_Doe is never high while OE_N=0.
- A new request is accepted no earlier than 2 cycles after Done (RELEASE, then IDLE).
- Addr and Wdata changes after sampling have no effect on the access in progress.

## Structure
- Package mem_seq_pkg:
  - mem_state_t enum.
  - Default IO_ADDR constant.
  - Strobe bundle struct {ce_n, oe_n, we_n, doe}.
- Sub-module mem_wait_counter: load/decrement/zero-flag counter parameterised by WAIT_CYC.
- The FSM, latches and I/O decode live in mem_sequencer.

## Test plan
- Reset low mid-WR_PULSE (WAIT_CYC=2) -> WE_N=1, SRAM_Doe=0 immediately; Done stays 0; state IDLE after reset is released.
- SRAM read:
  - Stimulus: Addr=16'h0003, SRAM model returns 16'h1234, Req_Rd held 6 cycles.
  - Response: OE_N low 3 cycles; Done pulses once at cycle 4; Rdata=16'h1234; no second access.
- SRAM write:
  - Stimulus: Addr=16'h0010, Wdata=16'hBEEF.
  - Response: WE_N low exactly 2 cycles, with SRAM_Dout=16'hBEEF one cycle either side; Done at cycle 5; the model holds 16'hBEEF at 16'h0010.
- I/O read and write:
  - Read with Addr=16'hFFFF, Switches=16'h00A5 -> Done at cycle 1, Rdata=16'h00A5, no SRAM strobe.
  - Write with Wdata=16'h0042 -> Hex_out=16'h0042.
- Req_Rd and Req_Wr both high at Addr=16'h0001 -> read performed; WE_N stays high throughout.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types for the SLC-3 memory sequencer: FSM states, strobe bundle,
// default I/O address and the state-to-strobe decode.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_CAP   = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5,
    DONE     = 3'd6,
    RELEASE  = 3'd7
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic doe;
  } strobe_t;

  localparam strobe_t STROBE_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, doe: 1'b0};

  // Doe is only ever set in write states, so it can never overlap OE_N=0.
  function automatic strobe_t strobe_decode(input mem_state_t s);
    strobe_t st;
    st = STROBE_OFF;
    case (s)
      RD_WAIT, RD_CAP: begin
        st.ce_n = 1'b0;
        st.oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        st.ce_n = 1'b0;
        st.doe  = 1'b1;
      end
      WR_PULSE: begin
        st.ce_n = 1'b0;
        st.we_n = 1'b0;
        st.doe  = 1'b1;
      end
      default: st = STROBE_OFF;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loads WAIT_CYC-1, decrements to zero, flags zero.
module mem_wait_counter #(
  parameter int WAIT_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_sequencer.sv
// SLC-3 memory sequencer: turns level read/write requests into timed SRAM
// strobes, decodes the switch/hex I/O address, and pulses Done per access.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int          WAIT_CYC = 2,
  parameter logic [15:0] IO_ADDR  = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Rd,
  input  logic        Req_Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  output logic [15:0] Rdata,
  output logic        Done,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  input  logic [15:0] SRAM_Din,
  output logic [15:0] SRAM_Dout,
  output logic        SRAM_Doe,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out
);

  mem_state_t  state_q, state_d;
  strobe_t     strb_q;
  logic [15:0] addr_q, wdata_q, rdata_q, hex_q;
  logic        done_q;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        sample, is_io;

  assign sample = (state_q == IDLE) && (Req_Rd || Req_Wr);
  assign is_io  = (Addr == IO_ADDR);

  mem_wait_counter #(.WAIT_CYC(WAIT_CYC)) u_wait (
    .clk_i   (Clk),
    .rst_n_i (Reset),
    .load_i  (cnt_load),
    .dec_i   (cnt_dec),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req_Rd)      state_d = is_io ? DONE : RD_WAIT;
        else if (Req_Wr) state_d = is_io ? DONE : WR_SETUP;
      end
      RD_WAIT: begin
        if (cnt_zero) state_d = RD_CAP;
        else          cnt_dec = 1'b1;
      end
      RD_CAP:   state_d = DONE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (cnt_zero) state_d = WR_HOLD;
        else          cnt_dec = 1'b1;
      end
      WR_HOLD:  state_d = DONE;
      DONE:     state_d = RELEASE;
      RELEASE: begin
        if (!Req_Rd && !Req_Wr) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
    cnt_load = ((state_d == RD_WAIT)  && (state_q != RD_WAIT)) ||
               ((state_d == WR_PULSE) && (state_q != WR_PULSE));
  end

  // Done is registered off the DONE state, so it rises as RELEASE is entered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      strb_q  <= STROBE_OFF;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strobe_decode(state_d);
      done_q  <= (state_q == DONE);
      if (sample) begin
        addr_q  <= Addr;
        wdata_q <= Wdata;
        if (is_io) begin
          if (Req_Rd) rdata_q <= Switches;
          else        hex_q   <= Wdata;
        end
      end
      if (state_q == RD_CAP) rdata_q <= SRAM_Din;
    end
  end

  assign Rdata     = rdata_q;
  assign Done      = done_q;
  assign Hex_out   = hex_q;
  assign SRAM_ADDR = {4'b0000, addr_q};
  assign SRAM_Dout = wdata_q;
  assign SRAM_CE_N = strb_q.ce_n;
  assign SRAM_OE_N = strb_q.oe_n;
  assign SRAM_WE_N = strb_q.we_n;
  assign SRAM_UB_N = strb_q.ce_n;
  assign SRAM_LB_N = strb_q.ce_n;
  assign SRAM_Doe  = strb_q.doe;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a small asynchronous SRAM model.
module tb_mem_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req_Rd, Req_Wr;
  logic [15:0] Addr, Wdata, Rdata, SRAM_Din, SRAM_Dout, Switches, Hex_out;
  logic        Done, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Doe;
  logic [19:0] SRAM_ADDR;

  logic [15:0] mem [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  int done_k, done_cnt, oe_cnt, we_cnt, doe_cnt, ce_cnt;
  int dout_bad, addr_bad, conflict, ublb_bad;

  always #5 Clk = ~Clk;

  mem_sequencer #(.WAIT_CYC(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_Rd    (Req_Rd),
    .Req_Wr    (Req_Wr),
    .Addr      (Addr),
    .Wdata     (Wdata),
    .Rdata     (Rdata),
    .Done      (Done),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_Din  (SRAM_Din),
    .SRAM_Dout (SRAM_Dout),
    .SRAM_Doe  (SRAM_Doe),
    .Switches  (Switches),
    .Hex_out   (Hex_out)
  );

  assign SRAM_Din = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[4:0]] : 16'h0000;

  always @(posedge SRAM_WE_N) begin
    if (!SRAM_CE_N && SRAM_Doe) mem[SRAM_ADDR[4:0]] = SRAM_Dout;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one request and watches 12 edges; edge 0 is the sampling edge.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input int hold);
    done_k = -1; done_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; ce_cnt = 0;
    dout_bad = 0; addr_bad = 0; conflict = 0; ublb_bad = 0;
    @(negedge Clk);
    Req_Rd = rd; Req_Wr = wr; Addr = a; Wdata = wd;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!SRAM_OE_N) oe_cnt++;
      if (!SRAM_WE_N) we_cnt++;
      if (!SRAM_CE_N) ce_cnt++;
      if (SRAM_Doe) begin
        doe_cnt++;
        if (SRAM_Dout !== wd) dout_bad++;
      end
      if (SRAM_Doe && !SRAM_OE_N) conflict++;
      if (SRAM_UB_N !== SRAM_CE_N || SRAM_LB_N !== SRAM_CE_N) ublb_bad++;
      if ((done_k < 0 || done_k == k) && SRAM_ADDR !== {4'h0, a}) addr_bad++;
      if (k == 0) begin Addr = 16'h0007; Wdata = 16'h1111; end
      if (k == hold - 1) begin Req_Rd = 1'b0; Req_Wr = 1'b0; end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[3] = 16'h1234;
    mem[1] = 16'h5555;
    Reset = 1'b0; Req_Rd = 1'b0; Req_Wr = 1'b0;
    Addr = 16'h0000; Wdata = 16'h0000; Switches = 16'h0000;
    #12;
    check_val("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Doe, Done}, 7'b1111100);
    check_val("rst_rdata", Rdata, 16'h0000);
    check_val("rst_hex", Hex_out, 16'h0000);
    check_val("rst_addr_dout", {12'h0, SRAM_ADDR, SRAM_Dout}, 48'h0);
    @(negedge Clk); Reset = 1'b1;

    access(1'b1, 1'b0, 16'h0003, 16'h0000, 6);
    check_val("rd_done_cycle", done_k, 4);
    check_val("rd_done_count", done_cnt, 1);
    check_val("rd_oe_cycles", oe_cnt, 3);
    check_val("rd_rdata", Rdata, 16'h1234);
    check_val("rd_no_write", we_cnt + doe_cnt, 0);
    check_val("rd_addr_stable", addr_bad, 0);

    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 6);
    check_val("wr_done_cycle", done_k, 5);
    check_val("wr_done_count", done_cnt, 1);
    check_val("wr_we_cycles", we_cnt, 2);
    check_val("wr_doe_cycles", doe_cnt, 4);
    check_val("wr_dout", dout_bad, 0);
    check_val("wr_no_oe", oe_cnt, 0);
    check_val("wr_mem", mem[16], 16'hBEEF);
    check_val("wr_addr_stable", addr_bad, 0);

    Switches = 16'h00A5;
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 2);
    check_val("io_rd_done_cycle", done_k, 1);
    check_val("io_rd_rdata", Rdata, 16'h00A5);
    check_val("io_rd_no_strobe", ce_cnt + oe_cnt + we_cnt + doe_cnt, 0);

    access(1'b0, 1'b1, 16'hFFFF, 16'h0042, 2);
    check_val("io_wr_done_cycle", done_k, 1);
    check_val("io_wr_hex", Hex_out, 16'h0042);
    check_val("io_wr_no_strobe", ce_cnt + oe_cnt + we_cnt + doe_cnt, 0);
    check_val("io_wr_rdata_held", Rdata, 16'h00A5);

    access(1'b1, 1'b1, 16'h0001, 16'hDEAD, 6);
    check_val("both_done_cycle", done_k, 4);
    check_val("both_oe_cycles", oe_cnt, 3);
    check_val("both_we_high", we_cnt, 0);
    check_val("both_rdata", Rdata, 16'h5555);
    check_val("both_hex_held", Hex_out, 16'h0042);
    check_val("both_mem_intact", mem[1], 16'h5555);
    check_val("all_doe_oe_overlap", conflict, 0);
    check_val("all_ublb", ublb_bad, 0);

    // Abort a write mid-pulse with reset.
    @(negedge Clk);
    Req_Wr = 1'b1; Addr = 16'h0012; Wdata = 16'h7777;
    @(posedge Clk); #1;
    Req_Wr = 1'b0;
    @(posedge Clk); #1;
    check_val("abort_we_low_before", SRAM_WE_N, 1'b0);
    #2 Reset = 1'b0;
    #1;
    check_val("abort_strobes_async", {SRAM_CE_N, SRAM_WE_N, SRAM_Doe}, 3'b110);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    @(negedge Clk); Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_rdata_reset", Rdata, 16'h0000);

    Switches = 16'h003C;
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 2);
    check_val("post_rst_idle_done", done_k, 1);
    check_val("post_rst_rdata", Rdata, 16'h003C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
